btn_gesture: RTL and testbench
==============================

// Module: btn_gesture
// PURPOSE
//  Downstream of the per-button debouncer. Consumes its one-cycle press/release pulses and classifies
//  each gesture into single click, double click or long press, each a one-cycle event pulse.
//  Feeds the game/menu control FSMs, which see clean events instead of raw timing.
// PARAMETERS
//  CLK_PER_MS  100_000  clock cycles per millisecond (100 MHz system clock)
//  LONG_MS     800      hold time from press to long-press event
//  DBL_MS      250      max release-to-second-press gap for a double click
//  REPEAT_MS   100      auto-repeat period while long-held (BTN_AUTOREPEAT_EN only)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous reset, active-high
//  btn_posedge   in   1  one-cycle pulse: debounced press
//  btn_negedge   in   1  one-cycle pulse: debounced release
//  click_pulse   out  1  one-cycle single-click event
//  dbl_pulse     out  1  one-cycle double-click event
//  long_pulse    out  1  one-cycle long-press event
//  held          out  1  level: high while in LONG state
//  repeat_pulse  out  1  one-cycle auto-repeat event (tied 0 when feature compiled out)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, all outputs 0. Reset mid-gesture discards the gesture; no event is emitted.
//  Cycle counts: LONG_CNT=LONG_MS*CLK_PER_MS, DBL_CNT=DBL_MS*CLK_PER_MS, REP_CNT=REPEAT_MS*CLK_PER_MS.
//  cnt width = $clog2(max count + 1). cnt is cleared on every state transition and never wraps.
//  Event outputs are registered. An event pulse is high for exactly one cycle, one clock after the
//  deciding edge or timeout is sampled.
//  FSM:
//   IDLE:   btn_posedge -> PRESS1.
//   PRESS1: cnt++. On btn_negedge -> GAP.
//           Else when cnt==LONG_CNT-1 -> LONG with long_pulse.
//           Release in the threshold cycle counts as a short press (negedge wins).
//   GAP:    cnt++. On btn_posedge -> PRESS2.
//           Else when cnt==DBL_CNT-1 -> IDLE with click_pulse.
//           Press in the timeout cycle wins (PRESS2).
//   PRESS2: wait for btn_negedge -> IDLE with dbl_pulse. No timeout: a long second press still
//           yields a double click on release.
//   LONG:   held=1. btn_negedge -> IDLE with no further event.
//  btn_posedge in PRESS1/PRESS2/LONG and btn_negedge in IDLE/GAP are protocol violations; they are
//  ignored and the state is unchanged.
//  The upstream debouncer never asserts both pulses in the same cycle. If it does, the state's
//  relevant input alone is acted on.
//  At most one of click/dbl/long/repeat is high in any cycle.
// CONFIGURATION
//  BTN_AUTOREPEAT_EN defined:
//   - In LONG, repeat_pulse fires every REP_CNT cycles. The first pulse comes REP_CNT cycles after
//     long_pulse.
//   - The counter restarts after each pulse and stops on release.
//  Not defined: repeat_pulse tied 0, REPEAT_MS unused, no repeat counter logic.
// STRUCTURE
//  Shared header btn_defs.vh: state encodings (IDLE, PRESS1, GAP, PRESS2, LONG) and the default
//  CLK_PER_MS. These are shared with the debouncer and the menu FSM.
//  One sub-module, gesture_timer: a loadable up-counter with clear, enable and compare-equal output,
//  instantiated once for the gesture timer and once for the repeat timer under BTN_AUTOREPEAT_EN.
// TESTING (bench: CLK_PER_MS=10, LONG_MS=8 ->80, DBL_MS=3 ->30, REPEAT_MS=2 ->20)
//  1. Press, release after 20 cycles, no further press -> click_pulse high 1 cycle, 31 cycles after
//     the negedge cycle. No other event.
//  2. Press 20, gap 10, press 20, release -> dbl_pulse 1 cycle after the second negedge. No click_pulse.
//  3. Press held 200 cycles -> long_pulse 81 cycles after posedge and held high until release.
//     With BTN_AUTOREPEAT_EN, repeat_pulse at +101, +121, ... (+181); without it, repeat_pulse
//     stays 0.
//  4. Release on exactly cycle 79 of the press -> short press path; click_pulse follows, long_pulse
//     never asserts.
//  5. Second press exactly on GAP cycle 29 -> PRESS2, then dbl_pulse on release. No click_pulse.
//  6. Assert rst during GAP and during LONG -> outputs 0 immediately (async), state IDLE, no pending
//     click emitted after rst deasserts.

Source files
------------

// File: rtl/btn_gesture_pkg.sv
// btn_gesture_pkg: shared gesture FSM state encoding, default clock rate and sizing helper.
package btn_gesture_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_t;

    localparam int DEF_CLK_PER_MS = 100_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_gesture_timer.sv
// gesture_timer: saturating up-counter with clear, load, enable and compare-equal hit.
//   clk, rst      clock, asynchronous active-high reset
//   clr           synchronous clear to zero (highest priority after reset)
//   en            count enable
//   load/load_val synchronous load
//   cmp_val       compare value
//   hit           cnt == cmp_val (combinational)
module gesture_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] cmp_val,
    output logic         hit
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign hit = cnt == cmp_val;

endmodule

// File: rtl/btn_gesture.sv
// btn_gesture: classifies debounced press/release pulses into click, double-click and long-press events.
//   clk, rst       clock, asynchronous active-high reset
//   btn_posedge    one-cycle debounced press pulse
//   btn_negedge    one-cycle debounced release pulse
//   click_pulse    one-cycle single-click event
//   dbl_pulse      one-cycle double-click event
//   long_pulse     one-cycle long-press event
//   held           high while the long press is held
//   repeat_pulse   one-cycle auto-repeat event while long-held
// Optional feature macro: BTN_AUTOREPEAT_EN enables auto-repeat; otherwise repeat_pulse is 0.
module btn_gesture
    import btn_gesture_pkg::*;
#(
    parameter int CLK_PER_MS = DEF_CLK_PER_MS,
    parameter int LONG_MS    = 800,
    parameter int DBL_MS     = 250,
    parameter int REPEAT_MS  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_posedge,
    input  logic btn_negedge,
    output logic click_pulse,
    output logic dbl_pulse,
    output logic long_pulse,
    output logic held,
    output logic repeat_pulse
);

    localparam int LONG_CNT = LONG_MS * CLK_PER_MS;
    localparam int DBL_CNT  = DBL_MS * CLK_PER_MS;
    localparam int REP_CNT  = REPEAT_MS * CLK_PER_MS;
    localparam int W        = $clog2(max3(LONG_CNT, DBL_CNT, REP_CNT) + 1);

    state_t state, next;
    logic   hit, click_next, dbl_next, long_next;

    // Events are decided in the cycle the edge or timeout is seen and registered below.
    always_comb begin
        next       = state;
        click_next = 1'b0;
        dbl_next   = 1'b0;
        long_next  = 1'b0;
        case (state)
            IDLE:   if (btn_posedge) next = PRESS1;
            PRESS1: begin
                if (btn_negedge) next = GAP;
                else if (hit) begin
                    next      = LONG;
                    long_next = 1'b1;
                end
            end
            GAP: begin
                if (btn_posedge) next = PRESS2;
                else if (hit) begin
                    next       = IDLE;
                    click_next = 1'b1;
                end
            end
            PRESS2: begin
                if (btn_negedge) begin
                    next     = IDLE;
                    dbl_next = 1'b1;
                end
            end
            LONG:   if (btn_negedge) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // The counter restarts on every state change, so it measures time spent in the current state.
    gesture_timer #(.W(W)) u_gesture (
        .clk      (clk),
        .rst      (rst),
        .clr      (next != state),
        .en       (state == PRESS1 || state == GAP),
        .load     (1'b0),
        .load_val ('0),
        .cmp_val  (state == GAP ? W'(DBL_CNT - 1) : W'(LONG_CNT - 1)),
        .hit      (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            click_pulse <= 1'b0;
            dbl_pulse   <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            state       <= next;
            click_pulse <= click_next;
            dbl_pulse   <= dbl_next;
            long_pulse  <= long_next;
        end
    end

    assign held = state == LONG;

`ifdef BTN_AUTOREPEAT_EN
    logic rep_hit, rep_next;

    // A release in the would-be repeat cycle suppresses that repeat.
    assign rep_next = state == LONG && !btn_negedge && rep_hit;

    gesture_timer #(.W(W)) u_repeat (
        .clk      (clk),
        .rst      (rst),
        .clr      (state != LONG || rep_next),
        .en       (state == LONG),
        .load     (1'b0),
        .load_val ('0),
        .cmp_val  (W'(REP_CNT - 1)),
        .hit      (rep_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            repeat_pulse <= 1'b0;
        else
            repeat_pulse <= rep_next;
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_gesture.sv
// tb_btn_gesture: table-driven gesture scenarios plus hand-written long-press, stray-edge and reset sequences.
module tb_btn_gesture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_posedge = 1'b0;
    logic btn_negedge = 1'b0;
    logic click_pulse, dbl_pulse, long_pulse, held, repeat_pulse;

    btn_gesture #(
        .CLK_PER_MS (10),
        .LONG_MS    (8),
        .DBL_MS     (3),
        .REPEAT_MS  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_posedge  (btn_posedge),
        .btn_negedge  (btn_negedge),
        .click_pulse  (click_pulse),
        .dbl_pulse    (dbl_pulse),
        .long_pulse   (long_pulse),
        .held         (held),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    int n_click, n_dbl, n_long, n_rep, n_multi;
    int last_evt, first_rep, last_rep, first_long;

    // Event monitor samples mid-cycle; cycle index is the number of rising edges seen so far.
    always @(negedge clk) begin
        if (!rst) begin
            n_click += int'(click_pulse);
            n_dbl   += int'(dbl_pulse);
            n_long  += int'(long_pulse);
            n_rep   += int'(repeat_pulse);
            if (click_pulse || dbl_pulse || long_pulse || repeat_pulse) last_evt = cyc;
            if (long_pulse && first_long < 0) first_long = cyc;
            if (repeat_pulse) begin
                if (first_rep < 0) first_rep = cyc;
                last_rep = cyc;
            end
            if (int'(click_pulse) + int'(dbl_pulse) + int'(long_pulse) + int'(repeat_pulse) > 1)
                n_multi++;
        end
    end

    task automatic clr_mon();
        n_click = 0; n_dbl = 0; n_long = 0; n_rep = 0; n_multi = 0;
        last_evt = -1; first_rep = -1; last_rep = -1; first_long = -1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_pos();
        btn_posedge = 1'b1;
        tick();
        btn_posedge = 1'b0;
    endtask

    task automatic pulse_neg();
        btn_negedge = 1'b1;
        tick();
        btn_negedge = 1'b0;
    endtask

    // p1: press length, gap: release-to-second-press, p2: second press length (0 = none).
    // last: cycle of the final event relative to the first press cycle.
    typedef struct {
        int p1;
        int gap;
        int p2;
        int clicks;
        int dbls;
        int longs;
        int last;
    } vec_t;

    vec_t vt[9];

    initial begin
        int c0;
        vt[0] = '{20,  0,   0, 1, 0, 0,  51};
        vt[1] = '{20, 10,  20, 0, 1, 0,  51};
        vt[2] = '{80,  0,   0, 1, 0, 0, 111};
        vt[3] = '{20, 30,  20, 0, 1, 0,  71};
        vt[4] = '{20, 31,  20, 2, 0, 0, 102};
        vt[5] = '{81,  0,   0, 0, 0, 1,  81};
        vt[6] = '{ 1,  0,   0, 1, 0, 0,  32};
        vt[7] = '{20,  5, 150, 0, 1, 0, 176};
        vt[8] = '{20, 29,   3, 0, 1, 0,  53};

        clr_mon();
        tick();
        chk("reset click", int'(click_pulse), 0);
        chk("reset dbl", int'(dbl_pulse), 0);
        chk("reset long", int'(long_pulse), 0);
        chk("reset held", int'(held), 0);
        chk("reset repeat", int'(repeat_pulse), 0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            clr_mon();
            c0 = cyc;
            pulse_pos();
            wait_until(c0 + vt[i].p1);
            pulse_neg();
            if (vt[i].p2 > 0) begin
                wait_until(c0 + vt[i].p1 + vt[i].gap);
                pulse_pos();
                wait_until(c0 + vt[i].p1 + vt[i].gap + vt[i].p2);
                pulse_neg();
            end
            wait_until(c0 + vt[i].p1 + vt[i].gap + vt[i].p2 + 60);
            chk($sformatf("vec%0d clicks", i), n_click, vt[i].clicks);
            chk($sformatf("vec%0d dbls", i), n_dbl, vt[i].dbls);
            chk($sformatf("vec%0d longs", i), n_long, vt[i].longs);
            chk($sformatf("vec%0d last event cycle", i), last_evt - c0, vt[i].last);
            chk($sformatf("vec%0d overlapping events", i), n_multi, 0);
        end

        // Stray press while pressed and stray release during the gap are ignored.
        clr_mon();
        c0 = cyc;
        pulse_pos();
        wait_until(c0 + 10);
        pulse_pos();
        wait_until(c0 + 20);
        pulse_neg();
        wait_until(c0 + 25);
        pulse_neg();
        wait_until(c0 + 90);
        chk("stray clicks", n_click, 1);
        chk("stray click cycle", last_evt - c0, 51);
        chk("stray other events", n_dbl + n_long, 0);

        // Long hold with release 200 cycles after the press.
        clr_mon();
        c0 = cyc;
        pulse_pos();
        wait_until(c0 + 80);
        chk("hold held before threshold", int'(held), 0);
        wait_until(c0 + 81);
        chk("hold held at long", int'(held), 1);
        wait_until(c0 + 200);
        chk("hold held before release", int'(held), 1);
        pulse_neg();
        chk("hold held after release", int'(held), 0);
        wait_until(c0 + 240);
        chk("hold long count", n_long, 1);
        chk("hold long cycle", first_long - c0, 81);
        chk("hold click/dbl", n_click + n_dbl, 0);
        chk("hold overlapping events", n_multi, 0);
`ifdef BTN_AUTOREPEAT_EN
        chk("hold repeat count", n_rep, 5);
        chk("hold first repeat", first_rep - c0, 101);
        chk("hold last repeat", last_rep - c0, 181);
`else
        chk("hold repeat count", n_rep, 0);
`endif

        // Reset during the gap discards the pending click.
        clr_mon();
        c0 = cyc;
        pulse_pos();
        wait_until(c0 + 20);
        pulse_neg();
        wait_until(c0 + 25);
        #2 rst = 1'b1;
        #1;
        chk("gap rst click", int'(click_pulse), 0);
        chk("gap rst held", int'(held), 0);
        tick();
        tick();
        rst = 1'b0;
        wait_until(c0 + 100);
        chk("gap rst no events", n_click + n_dbl + n_long + n_rep, 0);

        // Reset during a long hold drops held asynchronously; the later release is ignored.
        clr_mon();
        c0 = cyc;
        pulse_pos();
        wait_until(c0 + 90);
        chk("long rst held before", int'(held), 1);
        #2 rst = 1'b1;
        #1;
        chk("long rst held async", int'(held), 0);
        chk("long rst repeat", int'(repeat_pulse), 0);
        tick();
        rst = 1'b0;
        wait_until(c0 + 95);
        clr_mon();
        pulse_neg();
        wait_until(c0 + 200);
        chk("long rst no events", n_click + n_dbl + n_long + n_rep, 0);
        chk("long rst held after", int'(held), 0);

        // A normal click still works after reset.
        clr_mon();
        c0 = cyc;
        pulse_pos();
        wait_until(c0 + 20);
        pulse_neg();
        wait_until(c0 + 80);
        chk("post rst click", n_click, 1);
        chk("post rst click cycle", last_evt - c0, 51);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
